// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM condition-code and NZCV flag definitions
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

endpackage

// File: rtl/condcheck.sv
// rtl/condcheck.sv - combinational ARM condition evaluation from Cond and NZCV
module condcheck
  import arm_pkg::*;
#(
  parameter bit COND_NV_PASS = 1'b1
) (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[N_IDX];
  assign z = Flags[Z_IDX];
  assign c = Flags[C_IDX];
  assign v = Flags[V_IDX];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = COND_NV_PASS;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_mc.sv
// rtl/condlogic_mc.sv - multicycle ARM condition unit: NZCV flags, delayed pass bit, gated strobes
module condlogic_mc
  import arm_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST    = 4'b0000,
  parameter bit         COND_NV_PASS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_d_q, cond_ex_d_d;
  logic       cond_ex;
  logic       wr_nz, wr_cv;

  condcheck #(
    .COND_NV_PASS(COND_NV_PASS)
  ) u_condcheck (
    .Cond  (Cond),
    .Flags (flags_q),
    .CondEx(cond_ex)
  );

  // FlagW gates first so an unknown Cond cannot corrupt flags when no write is requested
  assign wr_nz = FlagW[1] & cond_ex;
  assign wr_cv = FlagW[0] & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (wr_nz) begin
      flags_d[N_IDX] = ALUFlags[N_IDX];
      flags_d[Z_IDX] = ALUFlags[Z_IDX];
    end
    if (wr_cv) begin
      flags_d[C_IDX] = ALUFlags[C_IDX];
      flags_d[V_IDX] = ALUFlags[V_IDX];
    end
    cond_ex_d_d = cond_ex;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= FLAGS_RST;
      cond_ex_d_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_d_q <= cond_ex_d_d;
    end
  end

  assign PCWrite  = (PCS & cond_ex_d_q) | NextPC;
  assign RegWrite = RegW & cond_ex_d_q;
  assign MemWrite = MemW & cond_ex_d_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_condlogic_mc.sv
// tb/tb_condlogic_mc.sv - directed self-checking bench for condlogic_mc
module tb_condlogic_mc;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  condlogic_mc dut (
    .clk     (clk),
    .reset   (reset),
    .Cond    (Cond),
    .ALUFlags(ALUFlags),
    .FlagW   (FlagW),
    .PCS     (PCS),
    .NextPC  (NextPC),
    .RegW    (RegW),
    .MemW    (MemW),
    .PCWrite (PCWrite),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite),
    .Flags   (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Loads an arbitrary NZCV value through an always-executed full flag write
  task automatic load_flags(input logic [3:0] v);
    ALUFlags = v;
    FlagW    = 2'b11;
    Cond     = 4'b1110;
    RegW     = 1'b0;
    MemW     = 1'b0;
    PCS      = 1'b0;
    step();
    FlagW    = 2'b00;
  endtask

  // Reference: ARM pairs each predicate with its inverse on Cond[0]
  function automatic logic ref_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b1;
    return base ^ c[0];
  endfunction

  initial begin
    reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;

    // Reset state, held across edges
    #3;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("rst_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("rst_pcwrite", {3'b0, PCWrite}, 4'd1);
    step();
    step();
    chk("rst_hold_regwrite", {3'b0, RegWrite}, 4'd0);
    reset = 1'b0; NextPC = 1'b0; MemW = 1'b0;
    #1;
    chk("rel_condexd_zero", {3'b0, RegWrite}, 4'd0);
    step();
    chk("rel_condexd_eval", {3'b0, RegWrite}, 4'd1);

    // Flag write then dependent EQ
    load_flags(4'b0000);
    Cond = 4'b0000; RegW = 1'b1;
    step();
    chk("eq_fail_before", {3'b0, RegWrite}, 4'd0);
    ALUFlags = 4'b0100; FlagW = 2'b11; Cond = 4'b1110; RegW = 1'b0;
    step();
    chk("fw_flags", Flags, 4'b0100);
    FlagW = 2'b00; Cond = 4'b0000; RegW = 1'b1;
    step();
    chk("fw_eq_regwrite", {3'b0, RegWrite}, 4'd1);

    // Split flag write
    load_flags(4'b0000);
    ALUFlags = 4'b1111; FlagW = 2'b10; Cond = 4'b1110;
    step();
    chk("split_nz", Flags, 4'b1100);
    ALUFlags = 4'b0011; FlagW = 2'b01;
    step();
    chk("split_cv", Flags, 4'b1111);

    // Failed condition suppresses everything
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1010;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    step();
    chk("fail_flags", Flags, 4'b0000);
    chk("fail_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("fail_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("fail_pcwrite", {3'b0, PCWrite}, 4'd0);

    // Same-cycle write and evaluate: old flags decide (NE with Z=0 passes)
    load_flags(4'b0000);
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
    step();
    chk("same_cyc_flags", Flags, 4'b0100);
    chk("same_cyc_regwrite", {3'b0, RegWrite}, 4'd1);

    // Signed spot checks
    load_flags(4'b1001);
    Cond = 4'b1010; RegW = 1'b1;
    step();
    chk("ge_1001", {3'b0, RegWrite}, 4'd1);
    load_flags(4'b1000);
    Cond = 4'b1011; RegW = 1'b1;
    step();
    chk("lt_1000", {3'b0, RegWrite}, 4'd1);
    load_flags(4'b0100);
    Cond = 4'b1100; RegW = 1'b1;
    step();
    chk("gt_0100", {3'b0, RegWrite}, 4'd0);

    // NextPC bypass with a failing condition, then PCS with a passing one
    NextPC = 1'b1; PCS = 1'b0;
    #1;
    chk("nextpc_bypass", {3'b0, PCWrite}, 4'd1);
    NextPC = 1'b0; PCS = 1'b1; Cond = 4'b1110;
    step();
    chk("pcs_pass", {3'b0, PCWrite}, 4'd1);

    // X on Cond with FlagW=00 must leave flags intact
    load_flags(4'b0110);
    Cond = 4'bxxxx; FlagW = 2'b00; ALUFlags = 4'b1001;
    step();
    chk("x_cond_flags", Flags, 4'b0110);
    Cond = 4'b1110;
    step();

    // Asynchronous reset mid-operation
    PCS = 1'b0; MemW = 1'b1; RegW = 1'b0;
    step();
    chk("pre_rst_memwrite", {3'b0, MemWrite}, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("async_rst_flags", Flags, 4'b0000);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_memwrite", {3'b0, MemWrite}, 4'd0);
    step();
    chk("post_rst_reeval", {3'b0, MemWrite}, 4'd1);
    MemW = 1'b0;

    // Full NZCV x Cond sweep
    for (int v = 0; v < 16; v++) begin
      for (int c = 0; c < 16; c++) begin
        load_flags(v[3:0]);
        chk($sformatf("sweep_flags_%0d", v), Flags, v[3:0]);
        Cond = c[3:0]; RegW = 1'b1;
        step();
        chk($sformatf("sweep_f%0d_c%0d", v, c), {3'b0, RegWrite},
            {3'b0, ref_pass(v[3:0], c[3:0])});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condlogic_mc.md
Name: condlogic_mc

Overview:
- Condition-check unit of the multicycle ARM datapath; the consumer end of the instruction decoder's control interface.
- Takes FlagW, PCS, NextPC, RegW and MemW from the decoder/main FSM, plus the condition field and the ALU flags.
- Holds the architectural NZCV flags and a one-cycle-delayed condition-pass bit.
- Emits the gated PCWrite, RegWrite and MemWrite strobes to the datapath.

Parameters:
- FLAGS_RST, 4'b0000, reset value of the NZCV flag register, ordered {N,Z,C,V}.
- COND_NV_PASS, 1, condition result for Cond=4'b1111 (1 = always execute, 0 = never).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Cond  input  4  Instr[31:28] condition field
- ALUFlags  input  4  ALU result flags {N,Z,C,V}, valid in ALU/execute states
- FlagW  input  2  [1] = write N,Z; [0] = write C,V
- PCS  input  1  PC-source write request (branch, or write to R15)
- NextPC  input  1  unconditional PC increment from the FSM (fetch)
- RegW  input  1  register-file write request
- MemW  input  1  memory write request
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  memory write enable
- Flags  output  4  current architectural {N,Z,C,V}

Behaviour:
- State: Flags[3:0] register; CondExD 1-bit register. Both are reset asynchronously; no other state.
- Reset values: Flags=FLAGS_RST; CondExD=0. While reset is asserted: RegWrite=0, MemWrite=0, PCWrite=NextPC.
- CondEx is combinational from Cond and the registered Flags (never ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 COND_NV_PASS
- Flag update: at posedge, Flags[3:2] <= ALUFlags[3:2] if FlagW[1]&CondEx; Flags[1:0] <= ALUFlags[1:0] if FlagW[0]&CondEx. The two halves are independent. Visible on Flags the cycle after.
- CondExD <= CondEx every cycle, unconditionally. The Cond field is stable across all non-fetch states because IR is held by IRWrite.
- Outputs are combinational from registered state:
  - PCWrite = (PCS & CondExD) | NextPC
  - RegWrite = RegW & CondExD
  - MemWrite = MemW & CondExD
- Latency: a flag written in an instruction's ALU state is seen by CondEx from the next cycle, so the next instruction's decode sees it. Write strobes lag the condition evaluation by exactly 1 cycle.
- Simultaneous flag write and condition evaluation in the same cycle: CondEx uses the old Flags; the update lands at the edge.
- NextPC bypasses the condition entirely, so fetch always advances the PC.
- Failed condition: FlagW, RegW, MemW and PCS are all suppressed. No partial effects.
- Reset mid-instruction: CondExD clears, so any pending RegW/MemW/PCS in the following cycles is suppressed until CondExD re-evaluates one cycle after reset release.
- Unknown/X on Cond must not propagate into Flags when FlagW=00; the enable is FlagW-gated first.

Decomposition:
- Shared package (arm_pkg): 4-bit condition-code constants COND_EQ..COND_NV; flag bit indices N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- One sub-module: condcheck (pure combinational Cond, Flags -> CondEx).
- Flag registers and CondExD flop stay in condlogic_mc.

Test Plan:
- Reset: assert reset with NextPC=1, RegW=1 -> Flags=0000, RegWrite=0, MemWrite=0, PCWrite=1; release -> CondExD=0 for one cycle.
- Flag write, then dependent condition: ALUFlags=0100, FlagW=11, Cond=1110 at edge -> Flags=0100 next cycle. Then Cond=0000 (EQ) -> CondExD=1 one cycle later; RegW=1 -> RegWrite=1.
- Split flag write: Flags=0000, ALUFlags=1111, FlagW=10, Cond=AL -> Flags=1100; then FlagW=01 with ALUFlags=0011 -> Flags=1111.
- Failed condition: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1010, RegW=1, MemW=1, PCS=1 -> Flags unchanged at 0000; RegWrite=0, MemWrite=0, PCWrite=0 (NextPC=0).
- Signed compares: sweep all 16 NZCV values × 16 Cond codes against a reference model. Spot checks: Flags=1001 with GE -> pass; Flags=1000 with LT -> pass; Flags=0100 with GT -> fail.
- NextPC bypass and reset mid-op: Cond failing, NextPC=1 -> PCWrite=1. Assert reset while CondExD=1 and MemW=1 -> MemWrite drops to 0 immediately (asynchronous).
